// File: rtl/vector_reflector_pipeline_param.sv
// rtl/vector_reflector_pipeline_param.sv - 4-stage streaming reflector r = v - 2*(v.n)*n with tag and facing flag
// Build macro REFLECT_SATURATE_EN: clamp out-of-range results instead of two's-complement wrap.
module vector_reflector_pipeline_param #(
  parameter int W     = 32,
  parameter int FRAC  = 24,
  parameter int TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3*W-1:0]     v,
  input  logic [3*W-1:0]     n,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [3*W-1:0]     r,
  output logic [TAG_W-1:0]   out_tag,
  output logic               front_face,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int PW = 2 * W;
  localparam int DW = W + 2;
  localparam int MW = DW + W;
  localparam int SW = W + 3;
  localparam int RW = W + 4;

  // One global enable: the whole pipe moves or the whole pipe holds.
  logic adv;
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  // Stage 1 registers
  logic                  valid1;
  logic [3*W-1:0]        v1;
  logic [3*W-1:0]        n1;
  logic [TAG_W-1:0]      tag1;
  logic [2:0][DW-1:0]    p1;
  logic [2:0][DW-1:0]    p1_next;

  // Stage 2 registers
  logic                  valid2;
  logic [3*W-1:0]        v2;
  logic [3*W-1:0]        n2;
  logic [TAG_W-1:0]      tag2;
  logic signed [DW-1:0]  dot2;
  logic                  ff2;
  logic [DW-1:0]         dot_next;

  // Stage 3 registers
  logic                  valid3;
  logic [3*W-1:0]        v3;
  logic [TAG_W-1:0]      tag3;
  logic                  ff3;
  logic [2:0][SW-1:0]    s3;
  logic [2:0][SW-1:0]    s3_next;

  // Stage 4 (output) next value
  logic [3*W-1:0]        r_next;

  genvar g;
  for (g = 0; g < 3; g++) begin : g_comp
    logic signed [W-1:0]  vin;
    logic signed [W-1:0]  nin;
    logic signed [PW-1:0] prod;
    logic signed [W-1:0]  n_s2;
    logic signed [MW-1:0] scaled;
    logic signed [W-1:0]  v_s3;
    logic signed [SW-1:0] s_s3;
    logic signed [RW-1:0] diff;

    assign vin  = v[g*W +: W];
    assign nin  = n[g*W +: W];
    assign prod = PW'(vin) * PW'(nin);
    assign p1_next[g] = DW'(prod >>> FRAC);

    // Shifting by FRAC-1 instead of FRAC folds the factor of two into the rescale.
    assign n_s2   = n2[g*W +: W];
    assign scaled = MW'(dot2) * MW'(n_s2);
    assign s3_next[g] = SW'(scaled >>> (FRAC - 1));

    assign v_s3 = v3[g*W +: W];
    assign s_s3 = s3[g];
    assign diff = RW'(v_s3) - RW'(s_s3);

`ifdef REFLECT_SATURATE_EN
    always_comb begin
      r_next[g*W +: W] = W'(diff);
      if (!(diff[RW-1:W-1] == '0 || diff[RW-1:W-1] == '1)) begin
        r_next[g*W +: W] = diff[RW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
    end
`else
    assign r_next[g*W +: W] = W'(diff);
`endif
  end

  assign dot_next = p1[0] + p1[1] + p1[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid1     <= 1'b0;
      v1         <= '0;
      n1         <= '0;
      tag1       <= '0;
      p1         <= '0;
      valid2     <= 1'b0;
      v2         <= '0;
      n2         <= '0;
      tag2       <= '0;
      dot2       <= '0;
      ff2        <= 1'b0;
      valid3     <= 1'b0;
      v3         <= '0;
      tag3       <= '0;
      ff3        <= 1'b0;
      s3         <= '0;
      out_valid  <= 1'b0;
      r          <= '0;
      out_tag    <= '0;
      front_face <= 1'b0;
    end else if (adv) begin
      valid1     <= in_valid;
      v1         <= v;
      n1         <= n;
      tag1       <= in_tag;
      p1         <= p1_next;

      valid2     <= valid1;
      v2         <= v1;
      n2         <= n1;
      tag2       <= tag1;
      dot2       <= dot_next;
      ff2        <= dot_next[DW-1];

      valid3     <= valid2;
      v3         <= v2;
      tag3       <= tag2;
      ff3        <= ff2;
      s3         <= s3_next;

      out_valid  <= valid3;
      r          <= r_next;
      out_tag    <= tag3;
      front_face <= ff3;
    end
  end

endmodule

// File: tb/tb_vector_reflector_pipeline_param.sv
// tb/tb_vector_reflector_pipeline_param.sv - randomized scoreboard bench for vector_reflector_pipeline_param
module tb_vector_reflector_pipeline_param;

  localparam int W     = 32;
  localparam int FRAC  = 24;
  localparam int TAG_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [3*W-1:0]     v;
  logic [3*W-1:0]     n;
  logic [TAG_W-1:0]   in_tag;
  logic               in_valid;
  logic               in_ready;
  logic [3*W-1:0]     r;
  logic [TAG_W-1:0]   out_tag;
  logic               front_face;
  logic               out_valid;
  logic               out_ready;

  vector_reflector_pipeline_param #(.W(W), .FRAC(FRAC), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .v(v), .n(n), .in_tag(in_tag), .in_valid(in_valid),
    .in_ready(in_ready), .r(r), .out_tag(out_tag), .front_face(front_face),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  typedef struct {
    logic [3*W-1:0]   r;
    logic [TAG_W-1:0] tag;
    logic             ff;
  } exp_t;
  exp_t expq[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Exact-math reference: wide signed arithmetic, floor scaling, then final reduction to W bits.
  function automatic void model(input logic [3*W-1:0] vv, input logic [3*W-1:0] nn,
                                output logic [3*W-1:0] rr, output logic ff);
    logic signed [127:0] vi [3];
    logic signed [127:0] ni [3];
    logic signed [127:0] dot, s, t, hi, lo;
    logic signed [W-1:0] tmp;
    hi  = (128'sd1 <<< (W - 1)) - 1;
    lo  = -(128'sd1 <<< (W - 1));
    dot = 0;
    for (int i = 0; i < 3; i++) begin
      tmp = vv[i*W +: W]; vi[i] = tmp;
      tmp = nn[i*W +: W]; ni[i] = tmp;
      dot = dot + ((vi[i] * ni[i]) >>> FRAC);
    end
    ff = (dot < 0);
    for (int i = 0; i < 3; i++) begin
      s = (2 * dot * ni[i]) >>> FRAC;
      t = vi[i] - s;
`ifdef REFLECT_SATURATE_EN
      if (t > hi) t = hi;
      if (t < lo) t = lo;
`else
      if (hi < lo) t = hi;
`endif
      rr[i*W +: W] = t[W-1:0];
    end
  endfunction

  function automatic logic [3*W-1:0] rand_vec(input bit big);
    logic [3*W-1:0]      vec;
    logic signed [W-1:0] c;
    for (int i = 0; i < 3; i++) begin
      c = $urandom;
      c = big ? (c >>> 1) : (c >>> 7);
      vec[i*W +: W] = c;
    end
    return vec;
  endfunction

  // Scoreboard and per-cycle protocol checks
  logic             prev_stall = 1'b0;
  logic [3*W-1:0]   prev_r;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_ff;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      expq.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, out_ready || !out_valid);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_r", r, prev_r);
        check("hold_tag", out_tag, prev_tag);
        check("hold_ff", front_face, prev_ff);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got tag %0h required no beat", out_tag);
        end else begin
          e = expq.pop_front();
          check("sb_r", r, e.r);
          check("sb_tag", out_tag, e.tag);
          check("sb_ff", front_face, e.ff);
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        model(v, n, e.r, e.ff);
        e.tag = in_tag;
        expq.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_r     = r;
      prev_tag   = out_tag;
      prev_ff    = front_face;
    end
  end

  // Present one beat (caller at posedge+1, pipe idle, out_ready=1) and capture its result.
  task automatic one_beat(input logic [3*W-1:0] vv, input logic [3*W-1:0] nn, input logic [TAG_W-1:0] tg,
                          output logic [3*W-1:0] rr, output logic [TAG_W-1:0] otg,
                          output logic ff, output int lat);
    v = vv; n = nn; in_tag = tg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    repeat (10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    rr = r; otg = out_tag; ff = front_face;
    @(posedge clk); #1;
  endtask

  logic [3*W-1:0]   rr;
  logic [TAG_W-1:0] otg;
  logic             ff;
  int               lat;
  localparam logic [W-1:0] ONE = 32'h0100_0000;

  initial begin
    int idx, t, start_out, first, ones, last;
    bit acc;
    bit pat [4];
    logic [3*W-1:0] bv, bn;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; v = '0; n = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_r", r, '0);
    check("rst_tag", out_tag, '0);
    check("rst_ff", front_face, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    one_beat({32'hFF6C32C6, 32'hFF6C32C6, 32'hFF6C32C6}, {32'h0, ONE, 32'h0}, 8'h5A, rr, otg, ff, lat);
    check("axis_latency", lat, 4);
    check("axis_r", rr, {32'hFF6C32C6, 32'h0093CD3A, 32'hFF6C32C6});
    check("axis_tag", otg, 8'h5A);
    check("axis_ff", ff, 1'b1);

    one_beat({32'h0, ONE, 32'h0}, {32'h0, ONE, 32'h0}, 8'h11, rr, otg, ff, lat);
    check("back_r", rr, {32'h0, 32'hFF000000, 32'h0});
    check("back_ff", ff, 1'b0);

    one_beat({32'h0, 32'h6400_0000, 32'h6400_0000}, {32'h0, ONE, ONE}, 8'h22, rr, otg, ff, lat);
`ifdef REFLECT_SATURATE_EN
    check("ovf_r", rr, {32'h0, 32'h8000_0000, 32'h8000_0000});
`else
    check("ovf_r", rr, {32'h0, 32'hD400_0000, 32'hD400_0000});
`endif
    check("ovf_ff", ff, 1'b0);

    bv = rand_vec(1'b1);
    one_beat(bv, '0, 8'h33, rr, otg, ff, lat);
    check("zero_n_r", rr, bv);
    check("zero_n_ff", ff, 1'b0);

    // Back-pressure: 16 beats, out_ready pattern 1,0,0,1
    start_out = n_out; idx = 0; t = 0;
    bv = rand_vec(1'b0); bn = rand_vec(1'b0);
    while (idx < 16 && t < 200) begin
      in_valid = 1'b1; v = bv; n = bn; in_tag = TAG_W'(idx); out_ready = pat[t % 4];
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; bv = rand_vec(1'b0); bn = rand_vec(1'b0); end
      t++;
    end
    in_valid = 1'b0;
    while ((expq.size() != 0 || out_valid) && t < 300) begin
      out_ready = pat[t % 4];
      @(posedge clk); #1;
      t++;
    end
    check("bp_beats_in", idx, 16);
    check("bp_beats_out", n_out - start_out, 16);
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Throughput: 32 back-to-back beats
    first = -1; ones = 0; last = -1;
    for (int k = 0; k < 44; k++) begin
      in_valid = (k < 32); v = rand_vec(k[0]); n = rand_vec(1'b0); in_tag = TAG_W'(k);
      @(negedge clk);
      if (out_valid) begin ones++; last = k; if (first < 0) first = k; end
      @(posedge clk); #1;
    end
    check("tp_first", first, 4);
    check("tp_count", ones, 32);
    check("tp_contig", last - first + 1, 32);

    // Reset mid-flight
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; v = rand_vec(1'b0); n = rand_vec(1'b0); in_tag = TAG_W'(8'hA0 + k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ones = 0;
    repeat (8) begin @(negedge clk); if (out_valid) ones++; end
    check("rst_flush", ones, 0);
    @(posedge clk); #1;
    one_beat(rand_vec(1'b0), rand_vec(1'b0), 8'hC3, rr, otg, ff, lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_tag", otg, 8'hC3);

    // Random traffic with random back-pressure
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 10) < 7;
      v = rand_vec($urandom % 2 == 0); n = rand_vec(1'b0); in_tag = TAG_W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    t = 0;
    while ((expq.size() != 0 || out_valid) && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
